multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
- Multicycle ARM-subset controller. Successor to the single-cycle `Control_Unit`.
- Sequences each instruction through a Moore FSM (fetch, decode, execute, memory, writeback).
- Holds the NZCV flag register and gates all architectural writes with condition evaluation.
- Drives the shared-memory multicycle datapath: one memory, an instruction register, and a multiplexed ALU source.

Parameters:
- ALU_CTRL_W, 3, width of ALUControl. Legal values: 2 or 3. EOR is decoded only when the value is ≥3.
- FLAG_W, 4, width of the flag register (NZCV). Fixed at 4; exposed so the package can check it.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-low reset
- Cond  in  4  Instr[31:28]
- Op  in  2  Instr[27:26]
- Funct  in  6  Instr[25:20]: [5]=I, [4:1]=cmd, [0]=S or L
- Rd  in  4  Instr[15:12]
- ALUFlags  in  FLAG_W  live NZCV from the ALU
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0=PC, 1=ALUOut
- MemWrite  out  1  memory write enable
- IRWrite  out  1  instruction register enable
- RegWrite  out  1  register file write enable
- ResultSrc  out  2  result select: 00=ALUOut, 01=Data, 10=ALUResult
- ALUSrcA  out  1  ALU A select: 0=RD1, 1=PC
- ALUSrcB  out  2  ALU B select: 00=RD2, 01=ExtImm, 10=const 4
- ImmSrc  out  2  immediate extender select = Op
- RegSrc  out  2  [0]=branch (read R15), [1]=store (read Rd)
- ALUControl  out  ALU_CTRL_W  ALU operation
- Flags  out  FLAG_W  current flag register contents

Behaviour:
- Reset (rst=0, asynchronous):
  - state=FETCH, Flags=0.
  - Every output is forced to 0 while rst=0.
  - First FETCH outputs appear on the cycle after rst rises.
- States and transitions:
  - FETCH→DECODE.
  - DECODE: Op=01→MEMADR; Op=00 with I=0→EXECUTER; Op=00 with I=1→EXECUTEI; Op=10→BRANCH; Op=11→FETCH.
  - MEMADR: L=1→MEMREAD, else MEMWRITE.
  - MEMREAD→MEMWB.
  - MEMWB, MEMWRITE, ALUWB, BRANCH → FETCH.
  - EXECUTER and EXECUTEI → ALUWB.
- Per-state outputs (unlisted outputs are 0):
  - FETCH: IRWrite=1, PCWrite=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALUControl=ADD.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcB=01, ALUControl=ADD.
  - MEMREAD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegW.
  - MEMWRITE: AdrSrc=1, MemW.
  - EXECUTER: ALUSrcB=00, ALUControl=decoded.
  - EXECUTEI: ALUSrcB=01, ALUControl=decoded.
  - ALUWB: ResultSrc=00, RegW.
  - BRANCH: ALUSrcB=01, ResultSrc=10, ALUControl=ADD, Branch.
- ImmSrc=Op and RegSrc are decoded combinationally in every state.
- Latency: DP=4 cycles, LDR=5, STR=4, B=3, Op=11=2 (no side effects).
- ALU decode (cmd → ALUControl): 0100 ADD=0, 0010 SUB=1, 0000 AND=2, 1100 ORR=3, 0001 EOR=4.
  - When ALU_CTRL_W=2, or cmd is any other value: illegal. ALUControl=ADD, RegW=0, FlagW=0.
- Condition evaluation:
  - CondEx is computed combinationally from Cond and the registered Flags.
  - All 14 ARM conditions are decoded; 1110 (AL) is true; 1111 is false.
- Gating:
  - RegWrite = RegW & CondEx & (Rd≠15).
  - MemWrite = MemW & CondEx.
  - PCWrite = FETCH | (Branch & CondEx) | (RegW & CondEx & Rd==15).
- Flag update:
  - FlagW[1] = S, controls NZ.
  - FlagW[0] = S & (ADD|SUB), controls CV.
  - Flags capture ALUFlags at the end of EXECUTER/EXECUTEI when FlagW bit is set & CondEx.
  - CondEx is evaluated against the pre-update flags.
- Mid-instruction reset: the FSM aborts to FETCH immediately; a pending write never occurs.

Optional Feature:
- Macro: CU_CMP_EN.
- Defined: cmd=1010 (CMP) decodes to ALUControl=SUB with RegW=0; FlagW[1] and FlagW[0] are forced to 1 regardless of S; the path still passes through ALUWB with no write.
- Undefined: cmd=1010 is illegal.

Decomposition:
- Package `cu_pkg` holds:
  - state enum
  - Op codes (OP_DP, OP_MEM, OP_BR)
  - cmd codes
  - ALU encodings
  - Cond codes
  - ResultSrc/ALUSrcB encodings
- One sub-module: `cond_logic`, which holds the flag register, CondEx evaluation and FlagW gating.
- The FSM and decode stay in the top.

Test Plan:
- Reset: rst=0 mid-EXECUTER with Funct=001000 → all outputs 0 immediately. After release: IRWrite=1, PCWrite=1 in the first cycle; Flags=0.
- ADD R1 (Cond=1110, Op=00, Funct=101001 (I=1, ADD, S=1), Rd=1, ALUFlags=0110 during EXECUTEI) → states FETCH, DECODE, EXECUTEI, ALUWB. RegWrite=1 in ALUWB only. Flags=0110 after EXECUTEI.
- LDR (Op=01, Funct=011001) → 5 cycles; AdrSrc=1 in MEMREAD; ResultSrc=01 with RegWrite=1 in MEMWB. STR (Funct=011000) → MemWrite=1 in MEMWRITE, 4 cycles total.
- Conditional branch BEQ (Cond=0000, Op=10):
  - Flags Z=0 → PCWrite=0 in BRANCH.
  - Flags=0100 → PCWrite=1 in BRANCH.
- Suppression:
  - SUBEQ with Z=0 → RegWrite=0 in ALUWB; flags unchanged.
  - Op=11 → DECODE returns to FETCH; no writes.
  - Rd=15 ADD → RegWrite=0, PCWrite=1 in ALUWB.
- CU_CMP_EN: Funct=010100 (cmd 1010, S=0), ALUFlags=0110 → ALUControl=1 in EXECUTER, RegWrite=0, Flags=0110. With the macro undefined → Flags remain 0.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared definitions for the multicycle ARM-subset controller: FSM states,
// instruction field codes, ALU operation encodings, condition codes and
// datapath mux select encodings.
package cu_pkg;

  // Flag register width (N, Z, C, V). The controller assumes exactly four bits.
  localparam int CU_FLAG_W = 4;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTER,
    S_EXECUTEI,
    S_ALUWB,
    S_BRANCH
  } state_t;

  // Instr[27:26]
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  // Data-processing cmd field, Instr[24:21]
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  // ALUControl encodings (EOR needs the 3-bit control width)
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_ORR = 3'd3;
  localparam logic [2:0] ALU_EOR = 3'd4;

  // Condition field, Instr[31:28]
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  // ResultSrc encodings
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ALUSrcB encodings
  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/cond_logic.sv
// Condition unit: holds the NZCV flag register, evaluates the instruction
// condition against the registered flags and commits ALU flags when the
// write-enables from the decoder are set and the condition passes.
module cond_logic
  import cu_pkg::*;
#(
  parameter int FLAG_W = CU_FLAG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        cond,
  input  logic [FLAG_W-1:0] alu_flags,
  input  logic [1:0]        flag_w,
  output logic              cond_ex,
  output logic [FLAG_W-1:0] flags
);

  logic n, z, c, v;
  assign {n, z, c, v} = flags[3:0];

  // Evaluate the condition field against the flags committed so far.
  always_comb begin
    // NOTE: every combinational output gets a default before the case so no path leaves it unassigned (no latch).
    cond_ex = 1'b0;
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~c | z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = ~z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      COND_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // Flag register: NZ and CV halves are written independently.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flags <= '0;
    end else begin
      // NOTE: sequential state is updated with non-blocking assignments so all registers see pre-edge values.
      if (flag_w[1] & cond_ex) flags[3:2] <= alu_flags[3:2];
      if (flag_w[0] & cond_ex) flags[1:0] <= alu_flags[1:0];
    end
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle ARM-subset control unit: Moore FSM sequencing fetch, decode,
// execute, memory and writeback over a shared-memory datapath, with
// condition-gated architectural writes.
// Optional feature: define CU_CMP_EN to decode cmd=1010 as CMP (SUB that
// always sets all four flags and never writes the register file).
module multicycle_control_unit
  import cu_pkg::*;
#(
  parameter int ALU_CTRL_W = 3,
  parameter int FLAG_W     = CU_FLAG_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            Cond,
  input  logic [1:0]            Op,
  input  logic [5:0]            Funct,
  input  logic [3:0]            Rd,
  input  logic [FLAG_W-1:0]     ALUFlags,
  output logic                  PCWrite,
  output logic                  AdrSrc,
  output logic                  MemWrite,
  output logic                  IRWrite,
  output logic                  RegWrite,
  output logic [1:0]            ResultSrc,
  output logic                  ALUSrcA,
  output logic [1:0]            ALUSrcB,
  output logic [1:0]            ImmSrc,
  output logic [1:0]            RegSrc,
  output logic [ALU_CTRL_W-1:0] ALUControl,
  output logic [FLAG_W-1:0]     Flags
);

  localparam bit EOR_OK = (ALU_CTRL_W >= 3);

  state_t state, next_state;

  logic [3:0] cmd;
  logic       s_bit;
  logic       dec_legal, dec_arith, dec_cmp;
  logic [2:0] dec_alu;

  logic       fetch, ir_write, adr_src, alu_src_a;
  logic [1:0] alu_src_b, result_src;
  logic [2:0] alu_sel;
  logic       reg_w, mem_w, branch, execute;

  logic [1:0]        flag_w;
  logic              cond_ex;
  logic [FLAG_W-1:0] flag_reg;
  logic              rd_pc;

  assign cmd   = Funct[4:1];
  assign s_bit = Funct[0];
  assign rd_pc = (Rd == 4'hF);

  // State register; reset aborts any instruction back to FETCH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_FETCH;
    else      state <= next_state;
  end

  // Data-processing cmd decode into ALU operation and legality.
  always_comb begin
    dec_alu   = ALU_ADD;
    dec_legal = 1'b1;
    dec_arith = 1'b0;
    dec_cmp   = 1'b0;
    case (cmd)
      CMD_ADD: begin dec_alu = ALU_ADD; dec_arith = 1'b1; end
      CMD_SUB: begin dec_alu = ALU_SUB; dec_arith = 1'b1; end
      CMD_AND: dec_alu = ALU_AND;
      CMD_ORR: dec_alu = ALU_ORR;
      CMD_EOR: begin
        if (EOR_OK) dec_alu = ALU_EOR;
        else        dec_legal = 1'b0;
      end
`ifdef CU_CMP_EN
      CMD_CMP: begin dec_alu = ALU_SUB; dec_cmp = 1'b1; end
`endif
      default: dec_legal = 1'b0;
    endcase
  end

  // Next-state and per-state raw controls (before condition gating).
  always_comb begin
    next_state = state;
    fetch      = 1'b0;
    ir_write   = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RD2;
    result_src = RES_ALUOUT;
    alu_sel    = ALU_ADD;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    branch     = 1'b0;
    execute    = 1'b0;
    case (state)
      S_FETCH: begin
        next_state = S_DECODE;
        fetch      = 1'b1;
        ir_write   = 1'b1;
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
      end
      S_DECODE: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        case (Op)
          OP_MEM:  next_state = S_MEMADR;
          OP_DP:   next_state = Funct[5] ? S_EXECUTEI : S_EXECUTER;
          OP_BR:   next_state = S_BRANCH;
          default: next_state = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alu_src_b  = SRCB_IMM;
        next_state = s_bit ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src    = 1'b1;
        next_state = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_w      = 1'b1;
        next_state = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src    = 1'b1;
        mem_w      = 1'b1;
        next_state = S_FETCH;
      end
      S_EXECUTER: begin
        alu_sel    = dec_alu;
        execute    = 1'b1;
        next_state = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_b  = SRCB_IMM;
        alu_sel    = dec_alu;
        execute    = 1'b1;
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        result_src = RES_ALUOUT;
        reg_w      = dec_legal & ~dec_cmp;
        next_state = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_b  = SRCB_IMM;
        result_src = RES_ALURESULT;
        branch     = 1'b1;
        next_state = S_FETCH;
      end
      default: next_state = S_FETCH;
    endcase
  end

  // Flag write enables are only live while an execute state is active.
  assign flag_w[1] = execute & dec_legal & (s_bit | dec_cmp);
  assign flag_w[0] = execute & dec_legal & ((s_bit & dec_arith) | dec_cmp);

  cond_logic #(
    .FLAG_W(FLAG_W)
  ) u_cond (
    .clk      (clk),
    .rst      (rst),
    .cond     (Cond),
    .alu_flags(ALUFlags),
    .flag_w   (flag_w),
    .cond_ex  (cond_ex),
    .flags    (flag_reg)
  );

  assign Flags = flag_reg;

  // Condition gating of writes, plus forcing every control low during reset.
  always_comb begin
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ImmSrc     = 2'b00;
    RegSrc     = 2'b00;
    ALUControl = '0;
    if (rst) begin
      PCWrite    = fetch | (branch & cond_ex) | (reg_w & cond_ex & rd_pc);
      AdrSrc     = adr_src;
      MemWrite   = mem_w & cond_ex;
      IRWrite    = ir_write;
      RegWrite   = reg_w & cond_ex & ~rd_pc;
      ResultSrc  = result_src;
      ALUSrcA    = alu_src_a;
      ALUSrcB    = alu_src_b;
      ImmSrc     = Op;
      RegSrc     = {(Op == OP_MEM) & ~s_bit, (Op == OP_BR)};
      ALUControl = alu_sel[ALU_CTRL_W-1:0];
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: an instruction-level
// model expands each instruction into its per-cycle control expectations.
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] Cond;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] ALUFlags;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA;
  logic [1:0] ResultSrc, ALUSrcB, ImmSrc, RegSrc;
  logic [2:0] ALUControl;
  logic [3:0] Flags;

  always #5 clk = ~clk;

  multicycle_control_unit dut (
    .clk       (clk),
    .rst       (rst),
    .Cond      (Cond),
    .Op        (Op),
    .Funct     (Funct),
    .Rd        (Rd),
    .ALUFlags  (ALUFlags),
    .PCWrite   (PCWrite),
    .AdrSrc    (AdrSrc),
    .MemWrite  (MemWrite),
    .IRWrite   (IRWrite),
    .RegWrite  (RegWrite),
    .ResultSrc (ResultSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ImmSrc    (ImmSrc),
    .RegSrc    (RegSrc),
    .ALUControl(ALUControl),
    .Flags     (Flags)
  );

  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic [1:0] reg_src;
    logic [2:0] alu_control;
    logic [3:0] flags;
  } outs_t;

  typedef enum {K_F, K_D, K_ADR, K_RD, K_MWB, K_MWR, K_EX, K_AWB, K_BR} step_t;

  outs_t act;
  assign act = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA,
                ALUSrcB, ImmSrc, RegSrc, ALUControl, Flags};

  int    n_vec = 0;
  int    n_err = 0;
  outs_t exp_o;
  bit    exp_valid = 1'b0;
  string exp_tag;
  logic [3:0] m_flags;
  outs_t last_obs;
  int    n;

  // Single compare process: checks every cycle the model has an expectation for.
  always @(negedge clk) begin
    if (exp_valid) begin
      n_vec++;
      if (act !== exp_o) begin
        n_err++;
        $display("FAIL %s: got %h required %h", exp_tag, act, exp_o);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, got, want);
    end
  endtask

  // ARM condition: the upper three bits pick a base test, bit 0 inverts it.
  function automatic bit m_cond(input logic [3:0] c, input logic [3:0] f);
    bit fn, fz, fc, fv, base;
    {fn, fz, fc, fv} = f;
    case (c[3:1])
      3'd0:    base = fz;
      3'd1:    base = fc;
      3'd2:    base = fn;
      3'd3:    base = fv;
      3'd4:    base = fc && !fz;
      3'd5:    base = (fn == fv);
      3'd6:    base = !fz && (fn == fv);
      default: base = 1'b1;
    endcase
    if (c == 4'b1111) return 1'b0;
    if (c[0] && c[3:1] != 3'd7) return !base;
    return base;
  endfunction

  function automatic void m_alu(input logic [3:0] cmd, output bit legal, output bit cmp,
                                output logic [2:0] code);
    legal = 1'b1;
    cmp   = 1'b0;
    code  = 3'd0;
    case (cmd)
      4'b0100: code = 3'd0;
      4'b0010: code = 3'd1;
      4'b0000: code = 3'd2;
      4'b1100: code = 3'd3;
      4'b0001: code = 3'd4;
`ifdef CU_CMP_EN
      4'b1010: begin code = 3'd1; cmp = 1'b1; end
`endif
      default: legal = 1'b0;
    endcase
  endfunction

  // Runs one instruction starting in its FETCH cycle (posedge+1). Stops after
  // max_steps cycles without advancing when the instruction is cut short.
  task automatic run_instr(input string tag, input logic [3:0] c, input logic [1:0] op,
                           input logic [5:0] fn, input logic [3:0] rd, input logic [3:0] af,
                           input int max_steps, output int steps);
    step_t seq[$];
    bit legal, cmp, ce, wr;
    logic [2:0] code;
    outs_t e;
    Cond = c; Op = op; Funct = fn; Rd = rd; ALUFlags = af;
    m_alu(fn[4:1], legal, cmp, code);
    seq.push_back(K_F);
    seq.push_back(K_D);
    case (op)
      2'b00: begin seq.push_back(K_EX); seq.push_back(K_AWB); end
      2'b01: begin
        seq.push_back(K_ADR);
        if (fn[0]) begin seq.push_back(K_RD); seq.push_back(K_MWB); end
        else seq.push_back(K_MWR);
      end
      2'b10: seq.push_back(K_BR);
      default: ;
    endcase
    steps = 0;
    for (int k = 0; k < seq.size(); k++) begin
      ce = m_cond(c, m_flags);
      e = '0;
      e.imm_src = op;
      e.reg_src = {op == 2'b01 && !fn[0], op == 2'b10};
      e.flags   = m_flags;
      case (seq[k])
        K_F:   begin e.ir_write = 1; e.pc_write = 1; e.alu_src_a = 1; e.alu_src_b = 2; e.result_src = 2; end
        K_D:   begin e.alu_src_a = 1; e.alu_src_b = 2; e.result_src = 2; end
        K_ADR: e.alu_src_b = 1;
        K_RD:  e.adr_src = 1;
        K_MWB: begin e.result_src = 1; e.reg_write = ce && rd != 15; e.pc_write = ce && rd == 15; end
        K_MWR: begin e.adr_src = 1; e.mem_write = ce; end
        K_EX:  begin e.alu_src_b = fn[5] ? 2'd1 : 2'd0; e.alu_control = code; end
        K_AWB: begin
          wr = legal && !cmp && ce;
          e.reg_write = wr && rd != 15;
          e.pc_write  = wr && rd == 15;
        end
        K_BR:  begin e.alu_src_b = 1; e.result_src = 2; e.pc_write = ce; end
        default: ;
      endcase
      exp_o = e;
      exp_tag = $sformatf("%s cycle %0d", tag, k);
      exp_valid = 1'b1;
      @(negedge clk);
      #1;
      exp_valid = 1'b0;
      last_obs = act;
      steps++;
      if (k + 1 == max_steps && k + 1 < seq.size()) return;
      @(posedge clk);
      #1;
      if (seq[k] == K_EX && legal && ce) begin
        if (fn[0] || cmp) m_flags[3:2] = af[3:2];
        if ((fn[0] && (code == 3'd0 || code == 3'd1)) || cmp) m_flags[1:0] = af[1:0];
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; Cond = '0; Op = '0; Funct = '0; Rd = '0; ALUFlags = '0;
    m_flags = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    check("reset outputs zero", 32'(act), 32'd0);
    rst = 1'b1;
    #1;
    check("first fetch IRWrite", 32'(IRWrite), 32'd1);
    check("first fetch PCWrite", 32'(PCWrite), 32'd1);

    run_instr("beq_not_taken", 4'b0000, 2'b10, 6'b000000, 4'd0, 4'b0000, 99, n);
    check("beq_nt length", 32'(n), 32'd3);
    check("beq_nt PCWrite", 32'(last_obs.pc_write), 32'd0);

    run_instr("subeq_skip", 4'b0000, 2'b00, 6'b000101, 4'd4, 4'b1001, 99, n);
    check("subeq RegWrite", 32'(last_obs.reg_write), 32'd0);
    check("subeq Flags", 32'(Flags), 32'h0);

    run_instr("adds_r1", 4'b1110, 2'b00, 6'b101001, 4'd1, 4'b0110, 99, n);
    check("adds_r1 length", 32'(n), 32'd4);
    check("adds_r1 RegWrite", 32'(last_obs.reg_write), 32'd1);
    check("adds_r1 Flags", 32'(Flags), 32'h6);

    run_instr("adds_z", 4'b1110, 2'b00, 6'b001001, 4'd2, 4'b0100, 99, n);
    check("adds_z Flags", 32'(Flags), 32'h4);

    run_instr("beq_taken", 4'b0000, 2'b10, 6'b000000, 4'd0, 4'b0000, 99, n);
    check("beq_t PCWrite", 32'(last_obs.pc_write), 32'd1);

    run_instr("ldr", 4'b1110, 2'b01, 6'b011001, 4'd2, 4'b0000, 99, n);
    check("ldr length", 32'(n), 32'd5);
    check("ldr ResultSrc", 32'(last_obs.result_src), 32'd1);
    check("ldr RegWrite", 32'(last_obs.reg_write), 32'd1);

    run_instr("str", 4'b1110, 2'b01, 6'b011000, 4'd3, 4'b0000, 99, n);
    check("str length", 32'(n), 32'd4);
    check("str MemWrite", 32'(last_obs.mem_write), 32'd1);

    run_instr("op11", 4'b1110, 2'b11, 6'b000000, 4'd0, 4'b0000, 99, n);
    check("op11 length", 32'(n), 32'd2);

    run_instr("add_pc", 4'b1110, 2'b00, 6'b001000, 4'd15, 4'b0000, 99, n);
    check("add_pc RegWrite", 32'(last_obs.reg_write), 32'd0);
    check("add_pc PCWrite", 32'(last_obs.pc_write), 32'd1);

    run_instr("eors", 4'b1110, 2'b00, 6'b000011, 4'd5, 4'b1011, 99, n);
    check("eors Flags", 32'(Flags), 32'h8);

    run_instr("orrmi", 4'b0100, 2'b00, 6'b111000, 4'd6, 4'b0000, 99, n);
    check("orrmi RegWrite", 32'(last_obs.reg_write), 32'd1);

    run_instr("andgt_skip", 4'b1100, 2'b00, 6'b000000, 4'd7, 4'b0000, 99, n);
    check("andgt RegWrite", 32'(last_obs.reg_write), 32'd0);

    run_instr("illegal_cmd", 4'b1110, 2'b00, 6'b011111, 4'd8, 4'b1111, 99, n);
    check("illegal RegWrite", 32'(last_obs.reg_write), 32'd0);
    check("illegal Flags", 32'(Flags), 32'h8);

    // Reset asserted in the middle of EXECUTER.
    run_instr("add_abort", 4'b1110, 2'b00, 6'b001000, 4'd9, 4'b1111, 3, n);
    rst = 1'b0;
    #1;
    check("mid reset outputs zero", 32'(act), 32'd0);
    @(posedge clk);
    #1;
    check("reset held outputs zero", 32'(act), 32'd0);
    rst = 1'b1;
    m_flags = 4'b0000;
    #1;
    check("post reset IRWrite", 32'(IRWrite), 32'd1);
    check("post reset PCWrite", 32'(PCWrite), 32'd1);
    check("post reset Flags", 32'(Flags), 32'h0);

    run_instr("cmp", 4'b1110, 2'b00, 6'b010100, 4'd10, 4'b0110, 99, n);
    check("cmp RegWrite", 32'(last_obs.reg_write), 32'd0);
`ifdef CU_CMP_EN
    check("cmp Flags", 32'(Flags), 32'h6);
`else
    check("cmp Flags", 32'(Flags), 32'h0);
`endif

    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
